// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
// Holds the sweep FSM states and the entry-count function.
package rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int depth_f(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Write, read and clear signal bundle for reg_file_mp.
// master drives requests, slave returns read data and busy.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic              re0;
  logic              re1;
  logic [ADDR_W-1:0] rAddr0;
  logic [ADDR_W-1:0] rAddr1;
  logic [DATA_W-1:0] rData0;
  logic [DATA_W-1:0] rData1;
  logic              rValid0;
  logic              rValid1;
  logic              clr;
  logic              busy;

  modport master (
    output we, wAddr, wData,
    output re0, re1, rAddr0, rAddr1,
    output clr,
    input  rData0, rData1,
    input  rValid0, rValid1,
    input  busy
  );

  modport slave (
    input  we, wAddr, wData,
    input  re0, re1, rAddr0, rAddr1,
    input  clr,
    output rData0, rData1,
    output rValid0, rValid1,
    output busy
  );
endinterface

// File: rtl/rf_read_port.sv
// One registered read port: address mux, write-first bypass,
// optional zero-register masking and output flops.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_mem [DEPTH],
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  always_comb begin
    w_data = i_mem[i_addr];
    if (i_we && (i_waddr == i_addr))
      w_data = i_wdata;
    if ((ZERO_REG != 0) && (i_addr == '0))
      w_data = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_re;
      if (i_re)
        r_data <= w_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/reg_file_mp.sv
// Flop-based register file: one write port, two read ports,
// and a one-entry-per-cycle clear sweep that blocks traffic.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input logic          clk,
  input logic          reset,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = depth_f(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_open;
  logic              w_wr;
  logic              w_re0;
  logic              w_re1;
  logic [DEPTH-1:0]  w_en;
  logic [DATA_W-1:0] w_din;

  // Traffic is accepted only when idle and no clear is being requested.
  assign w_open = (r_state == IDLE) && !bus.clr;
  assign w_wr   = bus.we  && w_open;
  assign w_re0  = bus.re0 && w_open;
  assign w_re1  = bus.re1 && w_open;
  assign w_din  = (r_state == CLEAR) ? '0 : bus.wData;

  always_comb begin
    w_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((r_state == CLEAR) && (r_idx == ADDR_W'(i)))
        w_en[i] = 1'b1;
      if (w_wr && (bus.wAddr == ADDR_W'(i)))
        w_en[i] = 1'b1;
    end
    if (ZERO_REG != 0)
      w_en[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset)
        r_mem[i] <= '0;
      else if (w_en[i])
        r_mem[i] <= w_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.clr) begin
            r_state <= CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_idx == LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_rp0 (
    .clk    (clk),
    .reset  (reset),
    .i_re   (w_re0),
    .i_addr (bus.rAddr0),
    .i_we   (w_wr),
    .i_waddr(bus.wAddr),
    .i_wdata(bus.wData),
    .i_mem  (r_mem),
    .o_data (bus.rData0),
    .o_valid(bus.rValid0)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_rp1 (
    .clk    (clk),
    .reset  (reset),
    .i_re   (w_re1),
    .i_addr (bus.rAddr1),
    .i_we   (w_wr),
    .i_waddr(bus.wAddr),
    .i_wdata(bus.wData),
    .i_mem  (r_mem),
    .o_data (bus.rData1),
    .o_valid(bus.rValid1)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a plain and a ZERO_REG instance share
// stimulus and are compared against an array-based model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  wAddr = '0;
  logic [31:0] wData = '0;
  logic        re0 = 1'b0;
  logic        re1 = 1'b0;
  logic [2:0]  rAddr0 = '0;
  logic [2:0]  rAddr1 = '0;
  logic        clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(3)) if0 ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(3)) if1 ();

  assign if0.we = we;      assign if1.we = we;
  assign if0.wAddr = wAddr; assign if1.wAddr = wAddr;
  assign if0.wData = wData; assign if1.wData = wData;
  assign if0.re0 = re0;    assign if1.re0 = re0;
  assign if0.re1 = re1;    assign if1.re1 = re1;
  assign if0.rAddr0 = rAddr0; assign if1.rAddr0 = rAddr0;
  assign if0.rAddr1 = rAddr1; assign if1.rAddr1 = rAddr1;
  assign if0.clr = clr;    assign if1.clr = clr;

  reg_file_mp #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) u_dut0 (
    .clk  (clk),
    .reset(rst),
    .bus  (if0.slave)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) u_dut1 (
    .clk  (clk),
    .reset(rst),
    .bus  (if1.slave)
  );

  logic [31:0] a_rd [2][2];
  logic        a_rv [2][2];
  logic        a_busy [2];
  assign a_rd[0][0] = if0.rData0;  assign a_rd[0][1] = if0.rData1;
  assign a_rd[1][0] = if1.rData0;  assign a_rd[1][1] = if1.rData1;
  assign a_rv[0][0] = if0.rValid0; assign a_rv[0][1] = if0.rValid1;
  assign a_rv[1][0] = if1.rValid0; assign a_rv[1][1] = if1.rValid1;
  assign a_busy[0] = if0.busy;     assign a_busy[1] = if1.busy;

  // Reference model: instance 1 has a hard-wired zero entry 0.
  logic [31:0] m_mem [2][8];
  logic [31:0] m_rd [2][2];
  logic        m_rv [2][2];
  int          m_left = 0;

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int a = 0; a < 8; a++) m_mem[i][a] = '0;
        for (int p = 0; p < 2; p++) begin
          m_rd[i][p] = '0;
          m_rv[i][p] = 1'b0;
        end
      end
      m_left = 0;
    end else begin
      bit acc;
      int ad;
      acc = (m_left == 0) && !clr;
      for (int i = 0; i < 2; i++)
        if (acc && we && !(i == 1 && wAddr == 0))
          m_mem[i][wAddr] = wData;
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          ad = (p == 0) ? int'(rAddr0) : int'(rAddr1);
          m_rv[i][p] = acc && ((p == 0) ? re0 : re1);
          if (m_rv[i][p])
            m_rd[i][p] = (i == 1 && ad == 0) ? 32'h0 : m_mem[i][ad];
        end
      end
      if (m_left > 0) begin
        for (int i = 0; i < 2; i++) m_mem[i][8 - m_left] = '0;
        m_left--;
      end else if (clr) begin
        m_left = 8;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; re0 = 0; re1 = 0; clr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (a_busy[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_busy dut%0d got %b want 0", i, a_busy[i]);
      end
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (a_rv[i][p] !== 1'b0 || a_rd[i][p] !== 32'h0) begin
          n_errors++;
          $display("FAIL reset_port dut%0d p%0d got v=%b d=%h want 0",
                   i, p, a_rv[i][p], a_rd[i][p]);
        end
      end
    end
    for (int a = 0; a < 8; a++) begin
      re0 = 1; rAddr0 = 3'(a);
      tick();
      n_checks++;
      if (if0.rData0 !== 32'h0 || if0.rValid0 !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_entry a%0d got v=%b d=%h want 1/0",
                 a, if0.rValid0, if0.rData0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    we = 1; wAddr = 5; wData = 32'hDEADBEEF;
    tick();
    we = 0; re0 = 1; rAddr0 = 5;
    tick();
    re0 = 0;
    n_checks++;
    if (if0.rData0 !== 32'hDEADBEEF || if0.rValid0 !== 1'b1) begin
      n_errors++;
      $display("FAIL write_read got v=%b d=%h want 1/deadbeef",
               if0.rValid0, if0.rData0);
    end
    tick();
    n_checks++;
    if (if0.rValid0 !== 1'b0 || if0.rData0 !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL idle_hold got v=%b d=%h want 0/deadbeef",
               if0.rValid0, if0.rData0);
    end
  endtask

  task automatic test_bypass();
    we = 1; wAddr = 3; wData = 32'h12345678;
    re0 = 1; re1 = 1; rAddr0 = 3; rAddr1 = 3;
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (a_rd[i][p] !== 32'h12345678 || a_rv[i][p] !== 1'b1) begin
          n_errors++;
          $display("FAIL bypass dut%0d p%0d got v=%b d=%h want 1/12345678",
                   i, p, a_rv[i][p], a_rd[i][p]);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    we = 1; wAddr = 0; wData = 32'hFFFFFFFF;
    re0 = 1; re1 = 1; rAddr0 = 0; rAddr1 = 0;
    tick();
    we = 0;
    n_checks++;
    if (if1.rData0 !== 32'h0 || if1.rData1 !== 32'h0) begin
      n_errors++;
      $display("FAIL zero_bypass got %h %h want 0 0",
               if1.rData0, if1.rData1);
    end
    n_checks++;
    if (if0.rData0 !== 32'hFFFFFFFF) begin
      n_errors++;
      $display("FAIL nonzero_bypass got %h want ffffffff", if0.rData0);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (if1.rData0 !== 32'h0 || if1.rData1 !== 32'h0 ||
        if1.rValid0 !== 1'b1 || if1.rValid1 !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_read got %h %h want 0 0",
               if1.rData0, if1.rData1);
    end
  endtask

  task automatic fill_all();
    for (int a = 0; a < 8; a++) begin
      we = 1; wAddr = 3'(a); wData = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      re0 = 1; re1 = 1; rAddr0 = 3'(a); rAddr1 = 3'(7 - a);
      tick();
      n_checks++;
      if (if0.rData0 !== 32'h0 || if0.rData1 !== 32'h0 ||
          if0.rValid0 !== 1'b1) begin
        n_errors++;
        $display("FAIL %s a%0d got %h %h v=%b want 0 0 1",
                 tag, a, if0.rData0, if0.rData1, if0.rValid0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int cnt;
    fill_all();
    clr = 1;
    tick();
    clr = 0;
    cnt = 0;
    for (int k = 0; k < 20 && if0.busy === 1'b1; k++) begin
      we = 1; wAddr = 3'($urandom_range(0, 7)); wData = $urandom;
      re0 = 1; re1 = 1;
      rAddr0 = 3'($urandom_range(0, 7));
      rAddr1 = 3'($urandom_range(0, 7));
      tick();
      cnt++;
      n_checks++;
      if (if0.rValid0 !== 1'b0 || if0.rValid1 !== 1'b0 ||
          if1.rValid0 !== 1'b0 || if1.rValid1 !== 1'b0) begin
        n_errors++;
        $display("FAIL sweep_drop k%0d got %b%b want 00",
                 k, if0.rValid0, if0.rValid1);
      end
    end
    idle_inputs();
    n_checks++;
    if (cnt != 8) begin
      n_errors++;
      $display("FAIL sweep_len got %0d want 8", cnt);
    end
    check_all_zero("clear_zero");
  endtask

  task automatic test_reset_mid_sweep();
    fill_all();
    clr = 1;
    tick();
    clr = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if (if0.busy !== 1'b0 || if1.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_busy got %b %b want 0 0", if0.busy, if1.busy);
    end
    check_all_zero("abort_zero");
  endtask

  task automatic test_clr_during_sweep();
    int cnt;
    fill_all();
    clr = 1;
    tick();
    cnt = 0;
    for (int k = 0; k < 20 && if0.busy === 1'b1; k++) begin
      clr = (cnt == 3);
      tick();
      cnt++;
    end
    clr = 0;
    n_checks++;
    if (cnt != 8) begin
      n_errors++;
      $display("FAIL reclr_len got %0d want 8", cnt);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (if0.busy !== 1'b0) begin
        n_errors++;
        $display("FAIL reclr_restart k%0d got %b want 0", k, if0.busy);
      end
    end
    check_all_zero("reclr_zero");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      clr = ($urandom_range(0, 24) == 0);
      we = $urandom_range(0, 1);
      re0 = $urandom_range(0, 1);
      re1 = $urandom_range(0, 1);
      wAddr = 3'($urandom_range(0, 7));
      rAddr0 = 3'($urandom_range(0, 7));
      rAddr1 = ($urandom_range(0, 3) == 0) ? wAddr
                                           : 3'($urandom_range(0, 7));
      wData = $urandom;
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (a_busy[i] !== (m_left > 0)) begin
          n_errors++;
          $display("FAIL rnd_busy c%0d dut%0d got %b want %b",
                   c, i, a_busy[i], (m_left > 0));
        end
        for (int p = 0; p < 2; p++) begin
          n_checks++;
          if (a_rv[i][p] !== m_rv[i][p] || a_rd[i][p] !== m_rd[i][p]) begin
            n_errors++;
            $display("FAIL rnd_read c%0d dut%0d p%0d got %b/%h want %b/%h",
                     c, i, p, a_rv[i][p], a_rd[i][p],
                     m_rv[i][p], m_rd[i][p]);
          end
        end
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_sweep();
    test_clr_during_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
